// File: rtl/max_seq_argmax.sv
// Sequential argmax engine: captures a packed score vector, scans one element per clock,
// and returns the index and value of the maximum under a ready/valid handshake.
module max_seq_argmax #(
   parameter int unsigned NUM_SIZE  = 26,
   parameter int unsigned NUM_COUNT = 10,
   parameter int unsigned IDX_W     = 4,
   parameter bit          SIGNED    = 1'b0
) (
   input  logic                          Clk,
   input  logic                          GlobalReset,
   input  logic                          InValid,
   output logic                          InReady,
   input  logic [NUM_SIZE*NUM_COUNT-1:0] Num,
   output logic                          OutValid,
   input  logic                          OutReady,
   output logic [IDX_W-1:0]              Index,
   output logic [NUM_SIZE-1:0]           MaxVal,
   output logic                          Busy
);

   // Counter must reach NUM_COUNT: the final SCAN cycle only hands over to DONE.
   localparam int unsigned CNT_W = $clog2(NUM_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_SIZE-1:0] max_q, max_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_SIZE-1:0] elem_q [NUM_COUNT];
   logic [NUM_SIZE-1:0] elem_d [NUM_COUNT];
   logic [NUM_SIZE-1:0] cur_elem;
   logic                cur_gt;
   logic                accept;
   logic                load;

   assign InReady  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & OutReady);
   assign accept   = InValid & InReady;
   assign OutValid = (state_q == ST_DONE);
   assign Busy     = (state_q == ST_SCAN);
   assign Index    = idx_q;
   assign MaxVal   = max_q;

   // Element currently under comparison
   always_comb begin
      cur_elem = '0;
      for (int unsigned i = 0; i < NUM_COUNT; i++) begin
         if (cnt_q == CNT_W'(i)) cur_elem = elem_q[i];
      end
   end

   // Strictly-greater compare keeps the lower index on ties
   generate
      if (SIGNED) begin : g_signed
         assign cur_gt = $signed(cur_elem) > $signed(max_q);
      end else begin : g_unsigned
         assign cur_gt = cur_elem > max_q;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      idx_d   = idx_q;
      elem_d  = elem_q;
      load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) load = 1'b1;
         end
         ST_SCAN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               if (cur_gt) begin
                  max_d = cur_elem;
                  idx_d = IDX_W'(cnt_q);
               end
               cnt_d = CNT_W'(cnt_q + 1'b1);
            end
         end
         ST_DONE: begin
            if (accept)        load    = 1'b1;
            else if (OutReady) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         for (int unsigned i = 0; i < NUM_COUNT; i++) begin
            elem_d[i] = Num[NUM_SIZE*i +: NUM_SIZE];
         end
         max_d   = Num[NUM_SIZE-1:0];
         idx_d   = '0;
         cnt_d   = CNT_W'(1);
         state_d = (NUM_COUNT == 1) ? ST_DONE : ST_SCAN;
      end
   end

   always_ff @(posedge Clk) begin
      if (GlobalReset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         max_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         idx_q   <= idx_d;
      end
   end

   // Captured vector needs no reset: it is only read after a load
   always_ff @(posedge Clk) begin
      elem_q <= elem_d;
   end

endmodule

// File: tb/tb_max_seq_argmax.sv
// Scoreboard bench for max_seq_argmax: unsigned and signed N=10 engines share stimulus,
// plus an N=1 engine for the single-element boundary.
module tb_max_seq_argmax;

   localparam int unsigned W  = 26;
   localparam int unsigned N  = 10;
   localparam int unsigned IW = 4;

   typedef logic [W*N-1:0] vec_t;
   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  val;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          in_valid, out_ready;
   vec_t          num;
   logic          in_ready_u, out_valid_u, busy_u;
   logic          in_ready_s, out_valid_s, busy_s;
   logic [IW-1:0] index_u, index_s;
   logic [W-1:0]  max_u, max_s;

   logic          in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [0:0]    index1;
   logic [W-1:0]  num1, max1;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_u[$];
   exp_t exp_s[$];

   logic [W-1:0] a [N];

   max_seq_argmax #(.NUM_SIZE(W), .NUM_COUNT(N), .IDX_W(IW), .SIGNED(1'b0)) u_dut_u (
      .Clk(clk), .GlobalReset(rst), .InValid(in_valid), .InReady(in_ready_u), .Num(num),
      .OutValid(out_valid_u), .OutReady(out_ready), .Index(index_u), .MaxVal(max_u),
      .Busy(busy_u));

   max_seq_argmax #(.NUM_SIZE(W), .NUM_COUNT(N), .IDX_W(IW), .SIGNED(1'b1)) u_dut_s (
      .Clk(clk), .GlobalReset(rst), .InValid(in_valid), .InReady(in_ready_s), .Num(num),
      .OutValid(out_valid_s), .OutReady(out_ready), .Index(index_s), .MaxVal(max_s),
      .Busy(busy_s));

   max_seq_argmax #(.NUM_SIZE(W), .NUM_COUNT(1), .IDX_W(1), .SIGNED(1'b0)) u_dut_1 (
      .Clk(clk), .GlobalReset(rst), .InValid(in_valid1), .InReady(in_ready1), .Num(num1),
      .OutValid(out_valid1), .OutReady(out_ready1), .Index(index1), .MaxVal(max1),
      .Busy(busy1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input vec_t v, input bit sgn);
      exp_t         r;
      logic [W-1:0] e;
      r.idx = '0;
      r.val = v[W-1:0];
      for (int unsigned i = 1; i < N; i++) begin
         e = v[W*i +: W];
         if (sgn ? ($signed(e) > $signed(r.val)) : (e > r.val)) begin
            r.val = e;
            r.idx = IW'(i);
         end
      end
      return r;
   endfunction

   function automatic vec_t pack(input logic [W-1:0] arr [N]);
      vec_t v;
      for (int unsigned i = 0; i < N; i++) v[W*i +: W] = arr[i];
      return v;
   endfunction

   function automatic vec_t rnd_vec(input int unsigned lim);
      vec_t v;
      for (int unsigned i = 0; i < N; i++)
         v[W*i +: W] = (lim == 0) ? W'($urandom) : W'($urandom_range(lim, 0));
      return v;
   endfunction

   // Scoreboard: pop and compare on every output handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid_u && out_ready) begin
            if (exp_u.size() == 0) chk("unexpected_u", 64'(1), 64'(0));
            else begin
               e = exp_u.pop_front();
               chk("idx_u", 64'(index_u), 64'(e.idx));
               chk("val_u", 64'(max_u), 64'(e.val));
            end
         end
         if (out_valid_s && out_ready) begin
            if (exp_s.size() == 0) chk("unexpected_s", 64'(1), 64'(0));
            else begin
               e = exp_s.pop_front();
               chk("idx_s", 64'(index_s), 64'(e.idx));
               chk("val_s", 64'(max_s), 64'(e.val));
            end
         end
      end
   end

   task automatic send(input vec_t v);
      in_valid = 1'b1;
      num      = v;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (in_ready_u) break;
      end
      if (!in_ready_u) chk("send_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_u.push_back(model(v, 1'b0));
      exp_s.push_back(model(v, 1'b1));
   endtask

   task automatic drain();
      for (int k = 0; k < 64; k++) begin
         if (exp_u.size() == 0 && exp_s.size() == 0) break;
         @(posedge clk);
      end
      chk("drain", 64'(exp_u.size() + exp_s.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ov();
      for (int k = 0; k < 40; k++) begin
         if (out_valid_u) break;
         @(posedge clk);
         #1;
      end
      chk("wait_ov", 64'(out_valid_u), 64'(1));
   endtask

   initial begin
      vec_t v;
      exp_t e;
      int   cyc;
      logic saw;

      in_valid   = 1'b0;
      num        = '0;
      out_ready  = 1'b1;
      in_valid1  = 1'b0;
      num1       = '0;
      out_ready1 = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_inready", 64'(in_ready_u), 64'(1));
      chk("rst_outvalid", 64'(out_valid_u), 64'(0));
      chk("rst_index", 64'(index_u), 64'(0));
      chk("rst_maxval", 64'(max_u), 64'(0));
      chk("rst_busy", 64'(busy_u), 64'(0));
      chk("rst_outvalid1", 64'(out_valid1), 64'(0));
      rst = 1'b0;

      // Basic unsigned scan with latency measurement
      a = '{26'd9, 26'd3, 26'd7, 26'd20, 26'd1, 26'd20, 26'd0, 26'd5, 26'd2, 26'd4};
      send(pack(a));
      cyc = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid_u) break;
      end
      chk("latency", 64'(cyc), 64'(10));
      chk("t1_idx", 64'(index_u), 64'(3));
      chk("t1_val", 64'(max_u), 64'(20));
      drain();

      // All-equal vector: lowest index wins
      for (int unsigned i = 0; i < N; i++) a[i] = 26'h155;
      send(pack(a));
      drain();

      // Negative scores, signed versus raw-unsigned ordering
      a = '{W'(-5), W'(-1), W'(-7), W'(-2), W'(-3), W'(-4), W'(-6), W'(-8), W'(-9), W'(-10)};
      send(pack(a));
      wait_ov();
      chk("t3_idx_s", 64'(index_s), 64'(1));
      chk("t3_val_s", 64'(max_s), 64'(26'h3FFFFFF));
      chk("t3_idx_u", 64'(index_u), 64'(1));
      chk("t3_val_u", 64'(max_u), 64'(26'h3FFFFFF));
      drain();
      a = '{W'(5), W'(-1), W'(3), W'(0), W'(2), W'(-20), W'(4), W'(1), W'(-3), W'(5)};
      send(pack(a));
      drain();

      // Back-to-back random vectors, some with narrow ranges to force ties
      for (int r = 0; r < 6; r++) send(rnd_vec((r % 2 == 0) ? 0 : 7));
      drain();

      // Backpressure hold, then accept a new vector on the releasing edge
      out_ready = 1'b0;
      v = rnd_vec(0);
      send(v);
      e = model(v, 1'b0);
      wait_ov();
      repeat (5) begin
         @(negedge clk);
         chk("hold_ov", 64'(out_valid_u), 64'(1));
         chk("hold_inrdy", 64'(in_ready_u), 64'(0));
         chk("hold_idx", 64'(index_u), 64'(e.idx));
         chk("hold_val", 64'(max_u), 64'(e.val));
      end
      @(posedge clk);
      #1;
      v         = rnd_vec(0);
      in_valid  = 1'b1;
      num       = v;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_u.push_back(model(v, 1'b0));
      exp_s.push_back(model(v, 1'b1));
      chk("b2b_busy", 64'(busy_u), 64'(1));
      chk("b2b_busy_s", 64'(busy_s), 64'(1));
      drain();

      // InValid during SCAN must be ignored
      send(rnd_vec(1000));
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      for (int unsigned i = 0; i < N; i++) a[i] = 26'h3FFFFF0 + W'(i);
      num = pack(a);
      @(negedge clk);
      chk("scan_inrdy", 64'(in_ready_u), 64'(0));
      @(posedge clk);
      #1;
      num = rnd_vec(0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();

      // Reset in the middle of a scan discards the vector
      for (int unsigned i = 0; i < N; i++) a[i] = W'(i + 1);
      send(pack(a));
      repeat (3) @(posedge clk);
      #1;
      exp_u.delete();
      exp_s.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_inready", 64'(in_ready_u), 64'(1));
      chk("abort_outvalid", 64'(out_valid_u), 64'(0));
      chk("abort_index", 64'(index_u), 64'(0));
      chk("abort_maxval", 64'(max_u), 64'(0));
      chk("abort_busy", 64'(busy_u), 64'(0));
      saw = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         saw = saw | out_valid_u | out_valid_s;
      end
      chk("abort_no_out", 64'(saw), 64'(0));

      // Single-element engine: result one edge after accept
      in_valid1 = 1'b1;
      num1      = 26'h2AB;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      chk("n1_outvalid", 64'(out_valid1), 64'(1));
      chk("n1_index", 64'(index1), 64'(0));
      chk("n1_maxval", 64'(max1), 64'(26'h2AB));
      chk("n1_busy", 64'(busy1), 64'(0));
      @(posedge clk);
      #1;
      chk("n1_consumed", 64'(out_valid1), 64'(0));

      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
